// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter and load controller for one shared N-bit hold register.
// R requesters present a word plus a request. One requester is granted at a
// time, and its word is loaded into Q. Q is then frozen for HOLD_CYC cycles
// before another grant is allowed. Q changes only on a granted load.
//
// Ports:
//   clk      in   1         rising-edge clock
//   reset_n  in   1         asynchronous active-low reset
//   req      in   R         per-requester load request (bit i = requester i)
//   din      in   R*N       flattened data, requester i on din[i*N +: N]
//   ack      out  R         one-cycle grant acknowledge, one-hot or zero
//   Q        out  N         shared register contents
//   owner    out  clog2(R)  index of the requester whose word is in Q
//   q_valid  out  1         Q holds a loaded word (sticky after first load)
//   busy     out  1         high while holding, no grant possible
//
// All outputs come straight from flops; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int R        = 4,
  parameter int HOLD_CYC = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [R-1:0]         req,
  input  logic [R*N-1:0]       din,
  output logic [R-1:0]         ack,
  output logic [N-1:0]         Q,
  output logic [$clog2(R)-1:0] owner,
  output logic                 q_valid,
  output logic                 busy
);

  localparam int PW    = $clog2(R);
  localparam int CNT_W = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [N-1:0]       data_q, data_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [R-1:0]       ack_q, ack_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               grant_found_s;
  logic [PW-1:0]      grant_idx_s;

  // Requester index at offset 'off' above the pointer, modulo R (R need not
  // be a power of two, so plain bit truncation is not enough).
  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int off);
    return PW'((int'(p) + off) % R);
  endfunction

  // Round-robin search: first set req bit starting at ptr and wrapping.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int off = 0; off < R; off++) begin
      if (!grant_found_s && req[wrap_idx(ptr_q, off)]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = wrap_idx(ptr_q, off);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Next-state and output-register logic for the IDLE/HOLD controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    owner_d = owner_q;
    ack_d   = '0;          // ack is a single-cycle pulse
    valid_d = valid_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_found_s) begin
          data_d  = din[grant_idx_s*N +: N];
          owner_d = grant_idx_s;
          ack_d   = R'(1) << grant_idx_s;
          valid_d = 1'b1;
          if (grant_idx_s == PW'(R - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = grant_idx_s + PW'(1);
          end
          cnt_d   = CNT_W'(HOLD_CYC);
          state_d = ST_HOLD;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // Leaving on the edge where the count reaches zero keeps busy high
        // for exactly HOLD_CYC cycles.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign ack     = ack_q;
  assign Q       = data_q;
  assign owner   = owner_q;
  assign q_valid = valid_q;
  assign busy    = busy_q;

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and load controller for one shared N-bit parallel-in/parallel-out hold register.
- R requesters each present a word plus a request. The block grants one requester at a time and loads its word into the register, then holds the value stable for a guaranteed window.
- Fixes the plain PIPO's inability to hold data: the register output changes only on a granted load.
- Sits between multiple producer blocks and any consumer of the registered word.

Parameters:
- N, 4, data width of the shared register (N >= 1).
- R, 4, number of requesters (R >= 2).
- HOLD_CYC, 2, cycles Q is held after a load before another grant is allowed (HOLD_CYC >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  R  per-requester load request; bit i belongs to requester i.
- din  input  R*N  flattened request data; requester i drives din[i*N +: N].
- ack  output  R  one-cycle grant/load acknowledge, one-hot or zero.
- Q  output  N  shared register contents.
- owner  output  $clog2(R)  index of the requester whose word is in Q.
- q_valid  output  1  Q holds a loaded word; stays high after the first load.
- busy  output  1  high while in HOLD, i.e. no grant possible.

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous and active-low (reset_n); it acts immediately, independent of clk.
- Reset values:
  - Q=0, ack=0, owner=0, q_valid=0, busy=0.
  - State=IDLE, hold counter=0.
  - Round-robin pointer ptr=0, so requester 0 has top priority first.
- States: IDLE, HOLD. All outputs are registered; no combinational paths from inputs to outputs.
- IDLE with req==0: nothing changes. Q holds its value regardless of din activity.
- IDLE with req!=0, at rising edge k:
  - Select the first set req bit searching upward from ptr, wrapping R-1 -> 0.
  - Q <= din slice of the winner; owner <= winner; ack[winner] <= 1; q_valid <= 1.
  - ptr <= (winner+1) mod R; hold counter <= HOLD_CYC; state <= HOLD; busy <= 1.
- Load latency: Q, owner and ack are visible in the cycle after the edge that sampled req. The load occurs on the same edge as grant selection.
- ack lasts exactly one cycle; ack <= 0 on the next edge.
- HOLD:
  - Counter decrements each edge; Q, owner and ptr are frozen.
  - When the counter reaches 0, state <= IDLE and busy <= 0 on that edge.
  - Busy is high for exactly HOLD_CYC cycles.
  - The next grant edge is at least HOLD_CYC+1 edges after the previous one.
- Requester rules:
  - Hold req and its din slice stable until ack is seen high.
  - Deassert req by the edge that follows the ack cycle.
  - HOLD_CYC >= 1 guarantees that the ack cycle cannot re-grant.
  - req may drop before ack (withdrawal). It is then simply not selected; no error is raised.
- Simultaneous requests: exactly one grant per arbitration edge, so all R bits set is serviced in rotating order. A requester that keeps req high is re-served only after every other active requester has had one grant (fairness bound R*(HOLD_CYC+1) cycles).
- Wrap-around: winner R-1 sets ptr to 0. Pointer arithmetic is modulo R, including non-power-of-two R.
- Reset mid-operation: an asserted reset_n=0 during HOLD or an ack cycle immediately returns all reset values. The pending ack is dropped and Q is cleared. After release, the first grant follows normal IDLE rules with ptr=0.
- req bits are used directly; requesters are synchronous to clk.

Test Plan:
- Reset/hold: after reset, check Q=0, q_valid=0, busy=0. Toggle din randomly with req=0 for 20 cycles -> Q stays 0 and ack stays 0.
- Single load: req=0001, din[3:0]=4'hA at edge k. After edge k: Q=4'hA, owner=0, ack=0001 for one cycle, busy=1 for 2 cycles. Then change din[3:0]=4'h5 with req=0 -> Q stays 4'hA.
- Round-robin: req=1111 held with din words 1,2,3,4 (requesters 0..3) -> grants in order 0,1,2,3,0 at edges spaced 3 cycles apart, Q sequence 1,2,3,4,1.
- Wrap and priority: ptr=3 after serving requester 2; req=1001 -> requester 3 is granted first (Q=din3), then requester 0 next.
- Withdrawal: req=0100 asserted during HOLD, then dropped before HOLD ends -> no ack is generated and Q is unchanged.
- Reset mid-HOLD: assert reset_n=0 one cycle after a load of 4'hC -> Q=0, busy=0, ack=0 immediately (before the next clk edge). After release with req=0010 -> requester 1 is granted.
